zap_dbus_bridge: RTL and testbench
==================================

Name: zap_dbus_bridge

Overview:
- Synthesizable responder for the ZAP core data port. It receives the core's read and write requests and holds the core in stall until each access completes.
- Each accepted access is forwarded to a simple req/ack external bus.
- Ends every access with read data or a data abort. An abort comes from a bus error, a bus timeout, or a user-mode access to the protected region.
- Sits between zap_top's data-memory pins and the system memory interconnect, in place of the simulation RAM model.

Parameters:
- TIMEOUT, 255: number of cycles in BUS without ack or err before the access aborts; range 1..65535.
- USER_BASE, 32'h0000_1000: user-mode accesses to addresses below this value abort without a bus cycle.

Ports:
- i_clk  in  1  core clock; all logic on the rising edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_rd_en  in  1  core load request.
- i_wr_en  in  1  core store request.
- i_address  in  32  byte address.
- i_ben  in  4  byte enables.
- i_wr_data  in  32  store data.
- i_user  in  1  user-mode translate flag from the core.
- o_stall  out  1  data stall to the core.
- o_abort  out  1  data abort to the core.
- o_rd_data  out  32  load data to the core.
- o_bus_req  out  1  external request.
- o_bus_we  out  1  1 = write.
- o_bus_addr  out  32  external address.
- o_bus_ben  out  4  external byte enables.
- o_bus_wdata  out  32  external write data.
- i_bus_ack  in  1  access complete.
- i_bus_err  in  1  access failed.
- i_bus_rdata  in  32  read data; valid with i_bus_ack.

Behaviour:
- Reset: while i_reset_n=0, state=IDLE. Every registered output is 0: o_abort, o_rd_data, o_bus_req, o_bus_we, o_bus_addr, o_bus_ben, o_bus_wdata. The timeout counter is 0.
- Reset mid-access drops o_bus_req immediately. A late ack or err after reset is ignored.
- States: IDLE, BUS, FAULT, DONE.
- o_stall is combinational: 1 when state is BUS or FAULT, or when state is IDLE and (i_rd_en or i_wr_en); 0 otherwise.
- IDLE, request present:
  - i_user=1 and i_address < USER_BASE (unsigned compare): go to FAULT. No bus cycle.
  - Otherwise: latch address, ben and wdata into the o_bus_* registers. Set o_bus_we=i_wr_en (write wins if both enables are high). Set o_bus_req=1, clear the counter, go to BUS.
- BUS, each cycle:
  - i_bus_err=1 (takes priority over ack): o_abort<=1, o_rd_data<=0, o_bus_req<=0, go to DONE.
  - Else i_bus_ack=1: o_rd_data<=i_bus_rdata for a read; o_rd_data holds its value for a write. o_abort<=0, o_bus_req<=0, go to DONE.
  - Else, if counter == TIMEOUT-1: treat as an error (abort).
  - Else: increment the counter.
  - o_bus_* stay stable for the whole time o_bus_req=1.
- FAULT: o_abort<=1, o_rd_data<=0, go to DONE.
- DONE: lasts exactly one cycle. o_stall=0, and o_rd_data and o_abort are valid for the core. The core consumes the access on this edge. Request enables seen during DONE are ignored. Go to IDLE and clear o_abort.
- A request still present in the cycle after DONE (i.e. in IDLE) is treated as a new access.
- Latency:
  - Bus access with ack in the first BUS cycle: o_stall is high for 2 cycles (IDLE, BUS), then DONE.
  - Each extra wait cycle adds 1 cycle of stall.
  - Protection fault: 2 stall cycles (IDLE, FAULT), then DONE.
  - Timeout: stall lasts 1+TIMEOUT cycles.
- ack or err arriving while in IDLE or DONE: ignored.

Test Plan:
- Read to 0x2000 with i_user=0; bus acks in the 3rd BUS cycle with rdata=32'hDEADBEEF → o_stall high 4 cycles; DONE shows o_rd_data=DEADBEEF, o_abort=0; o_bus_req high exactly 3 cycles.
- Write with i_wr_en=1, i_ben=4'b0011, data=32'h1234_5678, addr 0x3000 → o_bus_we=1, o_bus_ben=0011 and o_bus_wdata=12345678, all stable until ack; o_abort=0.
- User read of 0x0FFC with USER_BASE=0x1000 → o_bus_req never rises; DONE has o_abort=1 and o_rd_data=0. Same access with i_user=0 → normal bus cycle.
- TIMEOUT=4, no ack → o_bus_req high 4 cycles then drops; o_abort=1 in DONE; the next request is accepted normally.
- ack and err asserted together in the same cycle → o_abort=1. Both i_rd_en and i_wr_en high → o_bus_we=1.
- i_reset_n pulsed low while in BUS → o_bus_req=0 asynchronously and state=IDLE; an ack after reset is released causes no DONE cycle.

Source files
------------

// File: rtl/zap_dbus_bridge.sv
// ZAP core data-port responder: converts core loads/stores into single req/ack
// bus cycles, stalling the core until each access ends in data or an abort.
module zap_dbus_bridge #(
    parameter int          TIMEOUT   = 255,
    parameter logic [31:0] USER_BASE = 32'h0000_1000
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_rd_en,
    input  logic        i_wr_en,
    input  logic [31:0] i_address,
    input  logic [3:0]  i_ben,
    input  logic [31:0] i_wr_data,
    input  logic        i_user,
    output logic        o_stall,
    output logic        o_abort,
    output logic [31:0] o_rd_data,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [3:0]  o_bus_ben,
    output logic [31:0] o_bus_wdata,
    input  logic        i_bus_ack,
    input  logic        i_bus_err,
    input  logic [31:0] i_bus_rdata
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUS   = 2'd1,
        S_FAULT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] tmo_cnt;
    logic        req_any;
    logic        prot_fault;
    logic        tmo_hit;
    logic        bus_fail;

    assign req_any    = i_rd_en | i_wr_en;
    assign prot_fault = i_user && (i_address < USER_BASE);
    assign tmo_hit    = (tmo_cnt == 16'(TIMEOUT - 1));
    // Error outranks ack; a silent bus on the last allowed cycle counts as an error.
    assign bus_fail   = i_bus_err | (~i_bus_ack & tmo_hit);

    assign o_stall = (state == S_BUS) || (state == S_FAULT) ||
                     ((state == S_IDLE) && req_any);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (req_any) begin
                    state_nxt = prot_fault ? S_FAULT : S_BUS;
                end
            end
            S_BUS: begin
                if (i_bus_err || i_bus_ack || tmo_hit) begin
                    state_nxt = S_DONE;
                end
            end
            S_FAULT: state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Bus-side registers hold still for the whole time o_bus_req is high.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_abort     <= 1'b0;
            o_rd_data   <= 32'd0;
            o_bus_req   <= 1'b0;
            o_bus_we    <= 1'b0;
            o_bus_addr  <= 32'd0;
            o_bus_ben   <= 4'd0;
            o_bus_wdata <= 32'd0;
            tmo_cnt     <= 16'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_any && !prot_fault) begin
                        o_bus_req   <= 1'b1;
                        o_bus_we    <= i_wr_en;
                        o_bus_addr  <= i_address;
                        o_bus_ben   <= i_ben;
                        o_bus_wdata <= i_wr_data;
                        tmo_cnt     <= 16'd0;
                    end
                end
                S_BUS: begin
                    if (bus_fail) begin
                        o_abort   <= 1'b1;
                        o_rd_data <= 32'd0;
                        o_bus_req <= 1'b0;
                    end else if (i_bus_ack) begin
                        if (!o_bus_we) begin
                            o_rd_data <= i_bus_rdata;
                        end
                        o_abort   <= 1'b0;
                        o_bus_req <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                S_FAULT: begin
                    o_abort   <= 1'b1;
                    o_rd_data <= 32'd0;
                end
                S_DONE: begin
                    o_abort <= 1'b0;
                end
                default: begin
                    o_abort <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_zap_dbus_bridge.sv
// Bench for zap_dbus_bridge: directed scenarios plus random accesses against a
// transaction-level model of stall length, bus cycles, abort and read data.
module tb_zap_dbus_bridge;

    localparam int          TMO   = 4;
    localparam logic [31:0] UBASE = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd_en, wr_en, user;
    logic [31:0] address, wr_data;
    logic [3:0]  ben;
    logic        stall, abort, bus_req, bus_we;
    logic [31:0] rd_data, bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_ben;
    logic        bus_ack, bus_err;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [31:0] model_rd;

    zap_dbus_bridge #(.TIMEOUT(TMO), .USER_BASE(UBASE)) dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_rd_en(rd_en), .i_wr_en(wr_en), .i_address(address), .i_ben(ben),
        .i_wr_data(wr_data), .i_user(user),
        .o_stall(stall), .o_abort(abort), .o_rd_data(rd_data),
        .o_bus_req(bus_req), .o_bus_we(bus_we), .o_bus_addr(bus_addr),
        .o_bus_ben(bus_ben), .o_bus_wdata(bus_wdata),
        .i_bus_ack(bus_ack), .i_bus_err(bus_err), .i_bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    // Transaction-level model: the first of (ack, err, timeout) ends the access.
    function automatic void model(input logic rd, input logic wr, input logic usr,
                                  input logic [31:0] addr, input int ack_at, input int err_at,
                                  input logic [31:0] rdat, inout logic [31:0] mrd,
                                  output int e_stall, output int e_req, output logic e_abort);
        int inf, ea, ee, ev;
        inf = 1 << 30;
        if (usr && addr < UBASE) begin
            e_stall = 2; e_req = 0; e_abort = 1'b1; mrd = 32'd0;
            return;
        end
        ea = (ack_at > 0) ? ack_at : inf;
        ee = (err_at > 0) ? err_at : inf;
        ev = TMO;
        if (ea < ev) ev = ea;
        if (ee < ev) ev = ee;
        e_req   = ev;
        e_stall = 1 + ev;
        e_abort = !(ea == ev && ee != ev);
        if (e_abort)  mrd = 32'd0;
        else if (!wr) mrd = rdat;
        if (rd && !wr && !e_abort) mrd = rdat;
    endfunction

    // Drives one access and reports what the DUT did; ack/err fire on the Nth bus cycle (0 = never).
    task automatic run_access(input logic rd, input logic wr, input logic usr,
                              input logic [31:0] addr, input logic [3:0] b, input logic [31:0] wd,
                              input int ack_at, input int err_at, input logic [31:0] rdat,
                              output int n_stall, output int n_req, output logic ab,
                              output logic [31:0] rdo, output logic we_o, output logic [3:0] ben_o,
                              output logic [31:0] addr_o, output logic [31:0] wd_o,
                              output logic unstable, output logic finished);
        int k;
        n_stall = 0; n_req = 0; ab = 1'bx; rdo = 'x; unstable = 1'b0; finished = 1'b0;
        we_o = 1'bx; ben_o = 'x; addr_o = 'x; wd_o = 'x;
        k = 0;
        bus_rdata = rdat;
        while (!finished && k < 60) begin
            @(negedge clk);
            if (k == 0) begin
                rd_en = rd; wr_en = wr; user = usr; address = addr; ben = b; wr_data = wd;
            end
            bus_ack = 1'b0; bus_err = 1'b0;
            if (bus_req) begin
                n_req++;
                if (n_req == 1) begin
                    we_o = bus_we; ben_o = bus_ben; addr_o = bus_addr; wd_o = bus_wdata;
                end else if (bus_we !== we_o || bus_ben !== ben_o ||
                             bus_addr !== addr_o || bus_wdata !== wd_o) begin
                    unstable = 1'b1;
                end
                if (n_req == ack_at) bus_ack = 1'b1;
                if (n_req == err_at) bus_err = 1'b1;
            end
            #1;
            if (stall) begin
                n_stall++;
            end else if (k > 0) begin
                finished = 1'b1;
                ab = abort; rdo = rd_data;
                rd_en = 1'b0; wr_en = 1'b0;
            end
            k++;
        end
        if (!finished) begin
            rd_en = 1'b0; wr_en = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rd_en = 0; wr_en = 0; user = 0; address = 0; ben = 0; wr_data = 0;
        bus_ack = 0; bus_err = 0; bus_rdata = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({abort, rd_data, bus_req, bus_we, bus_addr, bus_ben, bus_wdata, stall} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got abort=%b rd=%h req=%b we=%b addr=%h ben=%h wd=%h stall=%b, want all 0",
                     abort, rd_data, bus_req, bus_we, bus_addr, bus_ben, bus_wdata, stall);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_spurious_ack();
        @(negedge clk);
        bus_ack = 1'b1; bus_err = 1'b1; bus_rdata = 32'hBAD0_BAD0;
        repeat (2) @(negedge clk);
        bus_ack = 1'b0; bus_err = 1'b0;
        #1;
        n_cmp++;
        if (abort !== 1'b0 || rd_data !== 32'd0 || bus_req !== 1'b0 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_ack_ignored: got abort=%b rd=%h req=%b stall=%b, want 0/0/0/0",
                     abort, rd_data, bus_req, stall);
        end
    endtask

    task automatic test_read();
        int ns, nr; logic ab, we, us, fin; logic [31:0] rdo, ad, wd; logic [3:0] be;
        run_access(1, 0, 0, 32'h2000, 4'hF, 32'h0, 3, 0, 32'hDEAD_BEEF, ns, nr, ab, rdo, we, be, ad, wd, us, fin);
        n_cmp++;
        if (!fin || ns != 4 || nr != 3) begin
            n_fail++;
            $display("FAIL read_latency: got done=%b stall=%0d req=%0d, want 1/4/3", fin, ns, nr);
        end
        n_cmp++;
        if (rdo !== 32'hDEAD_BEEF || ab !== 1'b0 || ad !== 32'h2000 || we !== 1'b0) begin
            n_fail++;
            $display("FAIL read_data: got rd=%h abort=%b addr=%h we=%b, want deadbeef/0/2000/0", rdo, ab, ad, we);
        end
        model_rd = 32'hDEAD_BEEF;
    endtask

    task automatic test_write();
        int ns, nr; logic ab, we, us, fin; logic [31:0] rdo, ad, wd; logic [3:0] be;
        run_access(0, 1, 0, 32'h3000, 4'b0011, 32'h1234_5678, 2, 0, 32'h5555_AAAA, ns, nr, ab, rdo, we, be, ad, wd, us, fin);
        n_cmp++;
        if (we !== 1'b1 || be !== 4'b0011 || wd !== 32'h1234_5678 || ad !== 32'h3000 || us) begin
            n_fail++;
            $display("FAIL write_bus: got we=%b ben=%b wd=%h addr=%h unstable=%b, want 1/0011/12345678/3000/0",
                     we, be, wd, ad, us);
        end
        n_cmp++;
        if (!fin || ab !== 1'b0 || rdo !== 32'hDEAD_BEEF || ns != 3) begin
            n_fail++;
            $display("FAIL write_done: got done=%b abort=%b rd=%h stall=%0d, want 1/0/deadbeef/3", fin, ab, rdo, ns);
        end
    endtask

    task automatic test_protection();
        int ns, nr; logic ab, we, us, fin; logic [31:0] rdo, ad, wd; logic [3:0] be;
        run_access(1, 0, 1, 32'h0FFC, 4'hF, 32'h0, 1, 0, 32'h7777_7777, ns, nr, ab, rdo, we, be, ad, wd, us, fin);
        n_cmp++;
        if (!fin || nr != 0 || ns != 2 || ab !== 1'b1 || rdo !== 32'd0) begin
            n_fail++;
            $display("FAIL user_fault: got done=%b req=%0d stall=%0d abort=%b rd=%h, want 1/0/2/1/0", fin, nr, ns, ab, rdo);
        end
        run_access(1, 0, 0, 32'h0FFC, 4'hF, 32'h0, 1, 0, 32'h7777_7777, ns, nr, ab, rdo, we, be, ad, wd, us, fin);
        n_cmp++;
        if (!fin || nr != 1 || ns != 2 || ab !== 1'b0 || rdo !== 32'h7777_7777) begin
            n_fail++;
            $display("FAIL kernel_ok: got done=%b req=%0d stall=%0d abort=%b rd=%h, want 1/1/2/0/77777777", fin, nr, ns, ab, rdo);
        end
        run_access(1, 0, 1, 32'h1000, 4'hF, 32'h0, 1, 0, 32'h0101_0101, ns, nr, ab, rdo, we, be, ad, wd, us, fin);
        n_cmp++;
        if (!fin || nr != 1 || ab !== 1'b0 || rdo !== 32'h0101_0101) begin
            n_fail++;
            $display("FAIL user_at_base: got done=%b req=%0d abort=%b rd=%h, want 1/1/0/01010101", fin, nr, ab, rdo);
        end
    endtask

    task automatic test_timeout();
        int ns, nr; logic ab, we, us, fin; logic [31:0] rdo, ad, wd; logic [3:0] be;
        run_access(1, 0, 0, 32'h4000, 4'hF, 32'h0, 0, 0, 32'h0, ns, nr, ab, rdo, we, be, ad, wd, us, fin);
        n_cmp++;
        if (!fin || nr != TMO || ns != 1 + TMO || ab !== 1'b1 || rdo !== 32'd0) begin
            n_fail++;
            $display("FAIL timeout: got done=%b req=%0d stall=%0d abort=%b rd=%h, want 1/%0d/%0d/1/0",
                     fin, nr, ns, ab, rdo, TMO, 1 + TMO);
        end
        run_access(1, 0, 0, 32'h4004, 4'hF, 32'h0, 1, 0, 32'hCAFE_F00D, ns, nr, ab, rdo, we, be, ad, wd, us, fin);
        n_cmp++;
        if (!fin || nr != 1 || ab !== 1'b0 || rdo !== 32'hCAFE_F00D) begin
            n_fail++;
            $display("FAIL after_timeout: got done=%b req=%0d abort=%b rd=%h, want 1/1/0/cafef00d", fin, nr, ab, rdo);
        end
        run_access(1, 0, 0, 32'h4008, 4'hF, 32'h0, TMO, 0, 32'h1111_2222, ns, nr, ab, rdo, we, be, ad, wd, us, fin);
        n_cmp++;
        if (!fin || nr != TMO || ab !== 1'b0 || rdo !== 32'h1111_2222) begin
            n_fail++;
            $display("FAIL ack_last_cycle: got done=%b req=%0d abort=%b rd=%h, want 1/%0d/0/11112222", fin, nr, ab, rdo, TMO);
        end
    endtask

    task automatic test_ack_err_both();
        int ns, nr; logic ab, we, us, fin; logic [31:0] rdo, ad, wd; logic [3:0] be;
        run_access(1, 0, 0, 32'h5000, 4'hF, 32'h0, 2, 2, 32'h9999_9999, ns, nr, ab, rdo, we, be, ad, wd, us, fin);
        n_cmp++;
        if (!fin || ab !== 1'b1 || rdo !== 32'd0 || nr != 2) begin
            n_fail++;
            $display("FAIL ack_err_same: got done=%b abort=%b rd=%h req=%0d, want 1/1/0/2", fin, ab, rdo, nr);
        end
        run_access(1, 1, 0, 32'h5004, 4'b1000, 32'hAB00_0000, 1, 0, 32'h8888_8888, ns, nr, ab, rdo, we, be, ad, wd, us, fin);
        n_cmp++;
        if (!fin || we !== 1'b1 || ab !== 1'b0 || rdo !== 32'd0) begin
            n_fail++;
            $display("FAIL both_enables: got done=%b we=%b abort=%b rd=%h, want 1/1/0/0", fin, we, ab, rdo);
        end
    endtask

    task automatic test_reset_mid_access();
        int k;
        @(negedge clk);
        rd_en = 1; wr_en = 0; user = 0; address = 32'h6000; ben = 4'hF;
        bus_ack = 0; bus_err = 0; bus_rdata = 32'h4242_4242;
        k = 0;
        while (!bus_req && k < 10) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        rd_en = 0;
        #1;
        n_cmp++;
        if (bus_req !== 1'b0 || stall !== 1'b0 || abort !== 1'b0 || rd_data !== 32'd0) begin
            n_fail++;
            $display("FAIL async_reset: got req=%b stall=%b abort=%b rd=%h, want 0/0/0/0", bus_req, stall, abort, rd_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus_ack = 1'b1;
        @(negedge clk);
        bus_ack = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if (bus_req !== 1'b0 || abort !== 1'b0 || rd_data !== 32'd0 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL late_ack: got req=%b abort=%b rd=%h stall=%b, want 0/0/0/0", bus_req, abort, rd_data, stall);
        end
        model_rd = 32'd0;
    endtask

    task automatic test_random();
        int ns, nr, e_ns, e_nr, ack_at, err_at; logic ab, we, us, fin, e_ab, r, w, u;
        logic [31:0] rdo, ad, wd, addr, wdat, rdat; logic [3:0] be, b;
        for (int i = 0; i < 40; i++) begin
            r = 1'($urandom); w = 1'($urandom);
            if (!r && !w) r = 1'b1;
            u = 1'($urandom);
            addr = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 32'h1FFF)) : $urandom;
            b = 4'($urandom); wdat = $urandom; rdat = $urandom;
            ack_at = $urandom_range(0, 6);
            err_at = ($urandom_range(0, 9) < 7) ? 0 : $urandom_range(1, 6);
            model(r, w, u, addr, ack_at, err_at, rdat, model_rd, e_ns, e_nr, e_ab);
            run_access(r, w, u, addr, b, wdat, ack_at, err_at, rdat, ns, nr, ab, rdo, we, be, ad, wd, us, fin);
            n_cmp++;
            if (!fin || ns != e_ns || nr != e_nr || ab !== e_ab || rdo !== model_rd) begin
                n_fail++;
                $display("FAIL rand_%0d: got done=%b stall=%0d req=%0d abort=%b rd=%h, want 1/%0d/%0d/%b/%h",
                         i, fin, ns, nr, ab, rdo, e_ns, e_nr, e_ab, model_rd);
            end
            if (e_nr > 0) begin
                n_cmp++;
                if (we !== w || be !== b || ad !== addr || wd !== wdat || us) begin
                    n_fail++;
                    $display("FAIL rand_bus_%0d: got we=%b ben=%h addr=%h wd=%h unstable=%b, want %b/%h/%h/%h/0",
                             i, we, be, ad, wd, us, w, b, addr, wdat);
                end
            end
        end
    endtask

    initial begin
        model_rd = 32'd0;
        test_reset();
        test_spurious_ack();
        test_read();
        test_write();
        test_protection();
        test_timeout();
        test_ack_err_both();
        test_reset_mid_access();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
